// File: rtl/psum_reader.sv
// Drains one captured HxW partial-sum frame as W column beats, requantising each element on
// the way out. Define PSUM_READER_RELU_EN to clamp negative outputs to zero.
module psum_reader #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned H          = 12,
  parameter int unsigned W          = 11,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter int unsigned SHIFT      = 8
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         frame_valid,
  output logic                                         frame_ready,
  input  logic [H-1:0][W-1:0][DATA_WIDTH-1:0]          frame_data,
  output logic                                         col_valid,
  input  logic                                         col_ready,
  output logic [H-1:0][OUT_WIDTH-1:0]                  col_data,
  output logic [$clog2(W)-1:0]                         col_idx,
  output logic                                         col_last,
  output logic                                         busy
);

  localparam int unsigned IdxW = $clog2(W);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(W - 1);

  // Rounding constant and saturation bounds, all in DATA_WIDTH+1 bits so the add cannot wrap.
  localparam int unsigned RndPos = (SHIFT == 0) ? 0 : SHIFT - 1;
  localparam logic [DATA_WIDTH:0] RndBit = (DATA_WIDTH + 1)'(1) << RndPos;
  localparam logic [DATA_WIDTH:0] Rnd = (SHIFT == 0) ? '0 : RndBit;
  localparam logic signed [DATA_WIDTH:0] MaxOut =
    {{(DATA_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [DATA_WIDTH:0] MinOut = ~MaxOut;

  typedef enum logic {StIdle, StStream} state_e;

  state_e                       state_q;
  logic [IdxW-1:0]              col_idx_q;
  logic signed [DATA_WIDTH-1:0] buf_q [H][W];

  function automatic logic [OUT_WIDTH-1:0] requant(input logic signed [DATA_WIDTH-1:0] x);
    logic signed [DATA_WIDTH:0] sum;
    logic signed [DATA_WIDTH:0] t;
    logic [OUT_WIDTH-1:0]       y;
    sum = $signed({x[DATA_WIDTH-1], x}) + $signed(Rnd);
    t   = sum >>> SHIFT;
    if (t > MaxOut) begin
      y = MaxOut[OUT_WIDTH-1:0];
    end else if (t < MinOut) begin
      y = MinOut[OUT_WIDTH-1:0];
    end else begin
      y = t[OUT_WIDTH-1:0];
    end
`ifdef PSUM_READER_RELU_EN
    if (y[OUT_WIDTH-1]) begin
      y = '0;
    end
`endif
    return y;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      col_idx_q <= '0;
      for (int i = 0; i < H; i++) begin
        for (int j = 0; j < W; j++) begin
          buf_q[i][j] <= '0;
        end
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (frame_valid) begin
            for (int i = 0; i < H; i++) begin
              for (int j = 0; j < W; j++) begin
                buf_q[i][j] <= $signed(frame_data[i][j]);
              end
            end
            col_idx_q <= '0;
            state_q   <= StStream;
          end
        end
        StStream: begin
          if (col_ready) begin
            if (col_idx_q == LastIdx) begin
              col_idx_q <= '0;
              state_q   <= StIdle;
            end else begin
              col_idx_q <= col_idx_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Output column is a pure function of the buffer and the registered column index.
  always_comb begin
    col_data = '0;
    for (int i = 0; i < H; i++) begin
      col_data[i] = requant(buf_q[i][col_idx_q]);
    end
  end

  assign frame_ready = (state_q == StIdle);
  assign col_valid   = (state_q == StStream);
  assign busy        = col_valid;
  assign col_idx     = col_idx_q;
  assign col_last    = col_valid && (col_idx_q == LastIdx);

endmodule

// File: doc/psum_reader.md
# psum_reader

Drain stage for the convolution accumulator. Captures one completed H×W partial-sum frame, then streams it out one column per handshake over a valid/ready interface. Each element is requantised on the way out: rounded arithmetic right shift, then saturation to OUT_WIDTH. It sits between the partial-sum accumulator (the frame producer) and the downstream activation/pooling/writeback logic (the column consumer).

## Interface
- DATA_WIDTH, 24, signed width of each incoming partial sum
- H, 12, rows per frame, which is also the elements per output column
- W, 11, columns per frame, which is also the column beats per frame
- OUT_WIDTH, 8, signed width of each requantised output element
- SHIFT, 8, arithmetic right-shift amount, range 0..DATA_WIDTH-1
- clk  in  1  single clock; all flops rising-edge
- rst  in  1  asynchronous, active-high reset
- frame_valid  in  1  frame_data holds a complete frame
- frame_ready  out  1  block can capture a frame
- frame_data  in  [H][W]×DATA_WIDTH signed  accumulated frame
- col_valid  out  1  col_data/col_idx/col_last valid
- col_ready  in  1  consumer accepts the current column
- col_data  out  [H]×OUT_WIDTH signed  requantised column col_idx
- col_idx  out  $clog2(W)  index of the column being presented
- col_last  out  1  high when col_idx == W-1 and col_valid
- busy  out  1  high in STREAM

## Operation
- States:
  - IDLE: frame_ready=1, col_valid=0.
  - STREAM: frame_ready=0, col_valid=1.
- IDLE→STREAM:
  - Taken on frame_valid && frame_ready at a clock edge.
  - The whole frame_data is latched into the internal buffer and col_idx is set to 0.
- STREAM, on col_valid && col_ready:
  - If col_idx < W-1, col_idx increments.
  - If col_idx == W-1, the block returns to IDLE.
- STREAM with col_ready=0: col_idx, col_data and col_last hold unchanged.
- frame_valid in STREAM is ignored and nothing is captured. The producer must hold frame_valid until frame_ready is high.
- The buffer is only written on capture. Changes on frame_data after capture do not affect the output.
- Requantisation, per element x:
  - Compute in DATA_WIDTH+1 bits: t = (x + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT. This is round-half-up toward +inf.
  - Saturate t to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - The rounding add never wraps.
- col_data depends only on registered state (the buffer and col_idx). There is no combinational path from col_ready or frame_valid to col_data or col_valid.
- Reset values: frame_ready=1, col_valid=0, col_data=0, col_idx=0, col_last=0, busy=0, state=IDLE, buffer=0.
- While rst is high, no capture occurs regardless of frame_valid.

## Timing
- Capture at edge N. col_valid and column 0 are visible in the cycle following edge N.
- With col_ready tied high:
  - Columns 0..W-1 appear on W consecutive cycles.
  - frame_ready rises in the cycle after the col_last handshake.
  - Throughput is one frame per W+1 cycles.
- Backpressure: each cycle with col_ready=0 in STREAM extends the frame by exactly one cycle.
- Reset mid-stream: asynchronous.
  - col_valid drops immediately and the state returns to IDLE.
  - The remaining columns are discarded.
  - The first post-reset capture is a clean new frame.
- A frame_valid pulse in the same cycle as the col_last handshake is not captured, because frame_ready=0 in that cycle.

## Configuration
- PSUM_READER_RELU_EN defined:
  - After saturation, any negative element is replaced by 0.
  - col_data range is then [0, 2^(OUT_WIDTH-1)-1].
- PSUM_READER_RELU_EN undefined:
  - Signed saturated values pass through unchanged.
- No other behaviour differs, including timing.

## Test plan
- Reset then idle: rst pulse → frame_ready=1, col_valid=0, col_data all 0, busy=0.
- Basic stream, default params, col_ready=1:
  - Stimulus: element[i][j] = 256·(i+j).
  - col_valid runs for 11 consecutive cycles, column j carries i+j, and col_last is high on j=10.
  - frame_ready returns in the next cycle.
- Rounding/saturation, SHIFT=8, OUT_WIDTH=8:
  - Inputs 383→1, 384→2, -385→-2.
  - 40000→127, -40000→-128.
  - With PSUM_READER_RELU_EN, -385→0 and -40000→0.
- Backpressure:
  - col_ready low for 3 cycles at col_idx=4 → col_idx, col_data and col_last stay stable.
  - Column 4 is delivered exactly once and the frame completes in 14 cycles.
- Ignored frame:
  - Assert frame_valid with new data during STREAM → output is unchanged and no second capture occurs.
  - The held frame_valid is captured in the first cycle frame_ready=1.
- Reset mid-operation:
  - Assert rst at col_idx=6 → col_valid=0 at once.
  - After release, a new frame streams starting from col_idx=0 with the new data.
